// File: rtl/io_interrupt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_interrupt_ctrl : edge-captured, masked, fixed-priority interrupt      |
// |                     controller with 64-bit vector and IO register port   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module io_interrupt_ctrl #(
   parameter int unsigned NUM_IRQ    = 8,
   parameter logic [63:0] VEC_BASE   = 64'h0000_0000_0000_0100,
   parameter logic [63:0] VEC_STRIDE = 64'h10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   output logic               interrupt,
   input  logic               int_ack,
   output logic [63:0]        int_vector,
   input  logic               io_cs,
   input  logic               io_wr,
   input  logic [1:0]         io_addr,
   input  logic [63:0]        io_din,
   output logic [63:0]        io_dout
);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_ASSERT  = 2'd1;
   localparam logic [1:0] c_SERVICE = 2'd2;

   localparam logic [1:0] c_ADDR_MASK   = 2'd0;
   localparam logic [1:0] c_ADDR_PEND   = 2'd1;
   localparam logic [1:0] c_ADDR_STATUS = 2'd2;
   localparam logic [1:0] c_ADDR_EOI    = 2'd3;

   logic [NUM_IRQ-1:0] r_irq_q;
   logic               r_ack_q;
   logic [NUM_IRQ-1:0] r_pending;
   logic [NUM_IRQ-1:0] r_mask;
   logic [NUM_IRQ-1:0] r_in_service;
   logic [1:0]         r_state;
   logic [2:0]         r_idx;
   logic [63:0]        r_int_vector;
   logic               r_interrupt;
   logic [63:0]        r_io_dout;

   logic               w_wr;
   logic               w_rd;
   logic               w_wr_mask;
   logic               w_wr_eoi;
   logic [NUM_IRQ-1:0] w_w1c;
   logic [NUM_IRQ-1:0] w_rise;
   logic               w_ack_rise;
   logic [NUM_IRQ-1:0] w_eligible;
   logic               w_any;
   logic [2:0]         w_sel;
   logic [NUM_IRQ-1:0] w_mask_nxt;
   logic [NUM_IRQ-1:0] w_pend_keep;
   logic [7:0]         w_mask8;
   logic [7:0]         w_pend8;
   logic               w_abort;
   logic               w_take_ack;
   logic [NUM_IRQ-1:0] w_ack_clr;
   logic [63:0]        w_status;
   logic [63:0]        w_rd_data;

   assign w_wr      = io_cs & io_wr;
   assign w_rd      = io_cs & ~io_wr;
   assign w_wr_mask = w_wr & (io_addr == c_ADDR_MASK);
   assign w_wr_eoi  = w_wr & (io_addr == c_ADDR_EOI);
   assign w_w1c     = (w_wr && io_addr == c_ADDR_PEND) ? io_din[NUM_IRQ-1:0] : '0;

   assign w_rise     = irq & ~r_irq_q;
   assign w_ack_rise = int_ack & ~r_ack_q;
   assign w_eligible = r_pending & r_mask;
   assign w_any      = |w_eligible;

   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      w_sel = 3'd0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_sel = 3'(i);
         end
      end
   end

   // The request being asserted is withdrawn if this cycle's mask write or
   // W1C would leave it disabled or not pending; a same-cycle edge keeps it.
   assign w_mask_nxt  = w_wr_mask ? io_din[NUM_IRQ-1:0] : r_mask;
   assign w_pend_keep = (r_pending & ~w_w1c) | w_rise;
   assign w_mask8     = 8'(w_mask_nxt);
   assign w_pend8     = 8'(w_pend_keep);
   assign w_abort     = ~(w_mask8[r_idx] & w_pend8[r_idx]);
   assign w_take_ack  = (r_state == c_ASSERT) & ~w_abort & w_ack_rise;

   always_comb begin
      w_ack_clr = '0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         w_ack_clr[i] = w_take_ack & (r_idx == 3'(i));
      end
   end

   always_comb begin
      w_status                = '0;
      w_status[NUM_IRQ-1:0]   = r_in_service;
      w_status[10:8]          = (r_state != c_IDLE) ? r_idx : 3'd0;
      w_status[63]            = r_interrupt;
   end

   always_comb begin
      w_rd_data = '0;
      case (io_addr)
         c_ADDR_MASK:   w_rd_data = 64'(r_mask);
         c_ADDR_PEND:   w_rd_data = 64'(r_pending);
         c_ADDR_STATUS: w_rd_data = w_status;
         c_ADDR_EOI:    w_rd_data = '0;
         default:       w_rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_irq_q      <= '0;
         r_ack_q      <= 1'b0;
         r_pending    <= '0;
         r_mask       <= '0;
         r_in_service <= '0;
         r_io_dout    <= '0;
      end else begin
         r_irq_q      <= irq;
         r_ack_q      <= int_ack;
         r_pending    <= (r_pending & ~(w_w1c | w_ack_clr)) | w_rise;
         r_mask       <= w_mask_nxt;
         r_in_service <= (w_wr_eoi ? '0 : r_in_service) | w_ack_clr;
         if (w_rd) begin
            r_io_dout <= w_rd_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= c_IDLE;
         r_idx        <= 3'd0;
         r_int_vector <= '0;
         r_interrupt  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any) begin
                  r_idx        <= w_sel;
                  r_int_vector <= VEC_BASE + 64'(w_sel) * VEC_STRIDE;
                  r_interrupt  <= 1'b1;
                  r_state      <= c_ASSERT;
               end
            end
            c_ASSERT: begin
               if (w_abort) begin
                  r_interrupt <= 1'b0;
                  r_state     <= c_IDLE;
               end else if (w_ack_rise) begin
                  r_interrupt <= 1'b0;
                  r_state     <= c_SERVICE;
               end
            end
            c_SERVICE: begin
               if (w_wr_eoi) begin
                  r_state <= c_IDLE;
               end
            end
            default: begin
               r_interrupt <= 1'b0;
               r_state     <= c_IDLE;
            end
         endcase
      end
   end

   assign interrupt  = r_interrupt;
   assign int_vector = r_int_vector;
   assign io_dout    = r_io_dout;

endmodule
`default_nettype wire

// File: tb/tb_io_interrupt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_io_interrupt_ctrl : directed + randomized bench with reference model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_io_interrupt_ctrl;

   logic        clk;
   logic        reset;
   logic [7:0]  irq;
   logic        interrupt;
   logic        int_ack;
   logic [63:0] int_vector;
   logic        io_cs;
   logic        io_wr;
   logic [1:0]  io_addr;
   logic [63:0] io_din;
   logic [63:0] io_dout;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0]  m_pending, m_mask, m_insvc, m_irq_prev;
   logic        m_ack_prev, m_int;
   int          m_phase;   // 0 waiting, 1 requesting, 2 being serviced
   int          m_idx;
   logic [63:0] m_vec, m_dout;

   io_interrupt_ctrl #(
      .NUM_IRQ    (8),
      .VEC_BASE   (64'h0000_0000_0000_0100),
      .VEC_STRIDE (64'h10)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .interrupt  (interrupt),
      .int_ack    (int_ack),
      .int_vector (int_vector),
      .io_cs      (io_cs),
      .io_wr      (io_wr),
      .io_addr    (io_addr),
      .io_din     (io_din),
      .io_dout    (io_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [63:0] model_read(input logic [1:0] a);
      logic [63:0] s;
      case (a)
         2'd0: return 64'(m_mask);
         2'd1: return 64'(m_pending);
         2'd2: begin
            s = 64'(m_insvc);
            if (m_phase != 0) s[10:8] = 3'(m_idx);
            s[63] = m_int;
            return s;
         end
         default: return 64'd0;
      endcase
   endfunction

   task automatic model_update();
      logic [7:0] rise, w1c, nmask, keep, ackclr;
      logic       ack_rise, wr, eoi;
      if (!reset) begin
         m_pending = 0; m_mask = 0; m_insvc = 0; m_irq_prev = 0; m_ack_prev = 0;
         m_int = 0; m_phase = 0; m_idx = 0; m_vec = 0; m_dout = 0;
         return;
      end
      wr       = io_cs & io_wr;
      rise     = irq & ~m_irq_prev;
      ack_rise = int_ack & ~m_ack_prev;
      w1c      = (wr && io_addr == 2'd1) ? io_din[7:0] : 8'h00;
      nmask    = (wr && io_addr == 2'd0) ? io_din[7:0] : m_mask;
      eoi      = wr && io_addr == 2'd3;
      ackclr   = 8'h00;
      if (io_cs && !io_wr) m_dout = model_read(io_addr);
      if (m_phase == 0) begin
         if ((m_pending & m_mask) != 0) begin
            m_idx   = lowest(m_pending & m_mask);
            m_vec   = 64'h100 + 64'(m_idx) * 64'h10;
            m_int   = 1'b1;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         keep = (m_pending & ~w1c) | rise;
         if (!nmask[m_idx] || !keep[m_idx]) begin
            m_int   = 1'b0;
            m_phase = 0;
         end else if (ack_rise) begin
            ackclr[m_idx] = 1'b1;
            m_int   = 1'b0;
            m_phase = 2;
         end
      end else begin
         if (eoi) m_phase = 0;
      end
      m_pending  = (m_pending & ~(w1c | ackclr)) | rise;
      m_insvc    = (eoi ? 8'h00 : m_insvc) | ackclr;
      m_mask     = nmask;
      m_irq_prev = irq;
      m_ack_prev = int_ack;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check("model_interrupt", 64'(interrupt), 64'(m_int));
      check("model_vector", int_vector, m_vec);
      check("model_dout", io_dout, m_dout);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [63:0] d);
      io_cs = 1'b1; io_wr = 1'b1; io_addr = a; io_din = d;
      tick();
      io_cs = 1'b0; io_wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [63:0] d);
      io_cs = 1'b1; io_wr = 1'b0; io_addr = a;
      tick();
      io_cs = 1'b0;
      d = io_dout;
   endtask

   initial begin
      logic [63:0] d;
      logic [31:0] r;
      reset = 1'b0; irq = 8'h00; int_ack = 1'b0;
      io_cs = 1'b0; io_wr = 1'b0; io_addr = 2'd0; io_din = 64'd0;

      // Reset then idle
      tick(); tick();
      check("rst_interrupt", 64'(interrupt), 64'd0);
      check("rst_dout", io_dout, 64'd0);
      check("rst_vector", int_vector, 64'd0);
      reset = 1'b1;
      wr_reg(2'd0, 64'd0);
      rd_reg(2'd2, d);
      check("idle_status", d, 64'd0);

      // Single request on irq[3]
      wr_reg(2'd0, 64'hFF);
      irq = 8'h08;
      tick();
      check("single_int_1cyc", 64'(interrupt), 64'd0);
      tick();
      check("single_int_2cyc", 64'(interrupt), 64'd1);
      check("single_vector", int_vector, 64'h130);
      irq = 8'h00; int_ack = 1'b1;
      tick();
      check("single_ack_drop", 64'(interrupt), 64'd0);
      int_ack = 1'b0;
      rd_reg(2'd1, d);
      check("single_pending", d, 64'd0);
      rd_reg(2'd2, d);
      check("single_insvc", 64'(d[7:0]), 64'h08);
      wr_reg(2'd3, 64'd0);
      rd_reg(2'd2, d);
      check("single_eoi_status", d, 64'd0);

      // Priority between irq[5] and irq[2]
      irq = 8'h24;
      tick(); tick();
      check("prio_first_vec", int_vector, 64'h120);
      irq = 8'h00; int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      wr_reg(2'd3, 64'd0);
      tick();
      check("prio_second_int", 64'(interrupt), 64'd1);
      check("prio_second_vec", int_vector, 64'h150);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      wr_reg(2'd3, 64'd0);

      // Mask and W1C
      wr_reg(2'd0, 64'd0);
      irq = 8'h02;
      tick();
      irq = 8'h00;
      tick(); tick();
      check("masked_no_int", 64'(interrupt), 64'd0);
      rd_reg(2'd1, d);
      check("masked_pending", d, 64'h02);
      wr_reg(2'd0, 64'h02);
      tick();
      check("unmask_int", 64'(interrupt), 64'd1);
      check("unmask_vec", int_vector, 64'h110);
      wr_reg(2'd1, 64'h02);
      check("w1c_drop", 64'(interrupt), 64'd0);
      tick();
      check("w1c_idle", 64'(interrupt), 64'd0);
      rd_reg(2'd1, d);
      check("w1c_pending", d, 64'd0);

      // Simultaneous set and clear on bit 4
      wr_reg(2'd0, 64'd0);
      irq = 8'h10;
      wr_reg(2'd1, 64'h10);
      rd_reg(2'd1, d);
      check("set_wins", 64'(d[4]), 64'd1);
      irq = 8'h00;
      wr_reg(2'd1, 64'h10);

      // Reset while in service with irq[0] pending
      wr_reg(2'd0, 64'hFF);
      irq = 8'h01;
      tick();
      irq = 8'h00;
      tick();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      irq = 8'h01;
      tick();
      irq = 8'h00;
      tick();
      rd_reg(2'd1, d);
      check("svc_pending_before_rst", d, 64'h01);
      reset = 1'b0;
      tick();
      check("midrst_int", 64'(interrupt), 64'd0);
      reset = 1'b1;
      rd_reg(2'd1, d);
      check("midrst_pending", d, 64'd0);
      rd_reg(2'd0, d);
      check("midrst_mask", d, 64'd0);
      rd_reg(2'd2, d);
      check("midrst_status", d, 64'd0);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      tick();
      check("stray_ack_int", 64'(interrupt), 64'd0);
      rd_reg(2'd2, d);
      check("stray_ack_status", d, 64'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         r       = $urandom;
         irq     = irq ^ (r[7:0] & r[15:8] & r[23:16]);
         int_ack = ($urandom_range(0, 3) == 0);
         io_cs   = ($urandom_range(0, 3) == 0);
         io_wr   = r[24];
         io_addr = r[26:25];
         io_din  = {$urandom, $urandom};
         if (io_cs && io_wr && io_addr == 2'd0 && r[27]) io_din[7:0] = 8'hFF;
         reset   = ($urandom_range(0, 199) != 0);
         tick();
      end
      reset = 1'b1; io_cs = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
